// File: rtl/npu_mmio_pkg.sv
// Shared definitions for the NPU byte-wide MMIO command issuer.
// Holds the MMIO register map and width macros, the issuer FSM state type,
// the write sequence length, and the mapping from a sequence slot to an
// MMIO address and byte select.
`ifndef NPU_MMIO_DEFINES
`define NPU_MMIO_DEFINES
`define HOST_DATA_WIDTH 8
`define ADDR_WIDTH      16
`define ARG_WIDTH       32
`define BUFFER_WIDTH    64
`define MMIO_ADDR_WIDTH 8
`define REG_CMD         8'h00
`define REG_ADDR        8'h01
`define REG_ARG         8'h03
`define REG_MMVR        8'h07
`define REG_STATUS      8'h0F
`endif

package npu_mmio_pkg;

    localparam int MMIO_AW       = `MMIO_ADDR_WIDTH;
    localparam int BYTE_W        = `HOST_DATA_WIDTH;
    localparam int WRITE_SEQ_LEN = 15;
    localparam int SEQ_IDX_W     = 4;
    localparam int LAST_SEQ_IDX  = WRITE_SEQ_LEN - 1;
    localparam int FLAT_W        = WRITE_SEQ_LEN * BYTE_W;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        HOLDOFF,
        POLL,
        RESP
    } issuer_state_t;

    // One slot of the write sequence: where the byte goes and which byte of
    // the flattened {mmvr, arg, addr, cmd} request it is.
    typedef struct packed {
        logic [MMIO_AW-1:0]   addr;
        logic [SEQ_IDX_W-1:0] byte_sel;
    } seq_slot_t;

    // Slot 0 is the command byte, 1..2 the address, 3..6 the argument and
    // 7..14 the MMVR payload, every multi-byte field little-endian.
    function automatic seq_slot_t seq_slot(input logic [SEQ_IDX_W-1:0] idx);
        seq_slot_t slot;
        slot.byte_sel = idx;
        if (idx == 4'd0) begin
            slot.addr = MMIO_AW'(`REG_CMD);
        end else if (idx < 4'd3) begin
            slot.addr = MMIO_AW'(int'(`REG_ADDR) + int'(idx) - 1);
        end else if (idx < 4'd7) begin
            slot.addr = MMIO_AW'(int'(`REG_ARG) + int'(idx) - 3);
        end else begin
            slot.addr = MMIO_AW'(int'(`REG_MMVR) + int'(idx) - 7);
        end
        return slot;
    endfunction

endpackage

// File: rtl/mmio_write_sequencer.sv
// Write-phase sequencer for the MMIO command issuer.
// Latches the request, walks the 15-slot byte sequence and presents the
// byte to issue next. With MMIO_ISSUER_SKIP_UNCHANGED_EN defined, a shadow
// of the slave's registers lets unchanged bytes be skipped; the final MMVR
// byte (doorbell) is always issued.
module mmio_write_sequencer
    import npu_mmio_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_first,
    input  logic                         issue_next,
    input  logic [`HOST_DATA_WIDTH-1:0]  req_cmd,
    input  logic [`ADDR_WIDTH-1:0]       req_addr,
    input  logic [`ARG_WIDTH-1:0]        req_arg,
    input  logic [`BUFFER_WIDTH-1:0]     req_mmvr,
    output logic [`MMIO_ADDR_WIDTH-1:0]  wr_addr,
    output logic [`HOST_DATA_WIDTH-1:0]  wr_data,
    output logic                         wr_last
);

    logic [FLAT_W-1:0]    req_flat;
    logic [FLAT_W-1:0]    latched_flat;
    logic [FLAT_W-1:0]    src_flat;
    logic [SEQ_IDX_W-1:0] next_idx;
    logic [SEQ_IDX_W-1:0] base_idx;
    logic [SEQ_IDX_W-1:0] sel_idx;
    seq_slot_t            slot;

    // On acceptance the first byte comes straight from the request inputs,
    // since the latched copy is only loaded at that same edge.
    assign req_flat = {req_mmvr, req_arg, req_addr, req_cmd};
    assign src_flat = issue_first ? req_flat : latched_flat;
    assign base_idx = issue_first ? '0 : next_idx;

`ifdef MMIO_ISSUER_SKIP_UNCHANGED_EN
    logic [FLAT_W-1:0] shadow;

    // Pick the lowest slot at or after base_idx whose byte differs from the
    // shadow; the doorbell slot is the fallback so it is always written.
    always_comb begin
        sel_idx = SEQ_IDX_W'(LAST_SEQ_IDX);
        for (int i = LAST_SEQ_IDX - 1; i >= 0; i--) begin
            if (i >= int'(base_idx) &&
                src_flat[i*BYTE_W +: BYTE_W] != shadow[i*BYTE_W +: BYTE_W]) begin
                sel_idx = SEQ_IDX_W'(i);
            end
        end
    end

    // Shadow tracks every byte actually written so it mirrors the slave.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (issue_first || issue_next) begin
            shadow[int'(sel_idx)*BYTE_W +: BYTE_W] <= wr_data;
        end
    end
`else
    // Without skipping, every slot is issued in order.
    always_comb begin
        sel_idx = base_idx;
    end
`endif

    // Map the selected slot to its MMIO address and byte.
    always_comb begin
        slot    = seq_slot(sel_idx);
        wr_addr = slot.addr;
        wr_data = src_flat[int'(slot.byte_sel)*BYTE_W +: BYTE_W];
        wr_last = (sel_idx == SEQ_IDX_W'(LAST_SEQ_IDX));
    end

    // Latch the request on acceptance and advance past each issued slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            latched_flat <= '0;
            next_idx     <= '0;
        end else begin
            if (issue_first) begin
                latched_flat <= req_flat;
            end
            if (issue_first || issue_next) begin
                next_idx <= sel_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_cmd_issuer.sv
// Host-side initiator for the NPU byte-wide MMIO register file.
// Accepts a command, writes it out byte by byte (last MMVR byte rings the
// doorbell), waits a holdoff, polls REG_STATUS until not-busy or timeout and
// returns the final status. Optional MMIO_ISSUER_SKIP_UNCHANGED_EN skips
// writes of bytes already present in the slave.
module mmio_cmd_issuer
    import npu_mmio_pkg::*;
#(
    parameter int BUSY_BIT       = 0,
    parameter int POLL_HOLDOFF   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [`HOST_DATA_WIDTH-1:0]  req_cmd,
    input  logic [`ADDR_WIDTH-1:0]       req_addr,
    input  logic [`ARG_WIDTH-1:0]        req_arg,
    input  logic [`BUFFER_WIDTH-1:0]     req_mmvr,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [`HOST_DATA_WIDTH-1:0]  rsp_status,
    output logic                         rsp_timeout,
    output logic [`MMIO_ADDR_WIDTH-1:0]  host_addr,
    output logic [`HOST_DATA_WIDTH-1:0]  host_wr_data,
    output logic                         host_wr_en,
    input  logic [`HOST_DATA_WIDTH-1:0]  host_rd_data
);

    localparam int HOLD_W = 4;
    localparam int POLL_W = $clog2(TIMEOUT_CYCLES + 1);

    issuer_state_t state;
    issuer_state_t next_state;

    logic                        issue_first;
    logic                        issue_next;
    logic                        cur_last;
    logic                        last_d;
    logic [HOLD_W-1:0]           hold_cnt;
    logic [POLL_W-1:0]           poll_cnt;
    logic                        poll_busy;
    logic                        poll_expired;
    logic [`MMIO_ADDR_WIDTH-1:0] seq_addr;
    logic [`HOST_DATA_WIDTH-1:0] seq_data;
    logic                        seq_last;
    logic [`MMIO_ADDR_WIDTH-1:0] host_addr_d;
    logic [`HOST_DATA_WIDTH-1:0] host_wr_data_d;
    logic                        host_wr_en_d;

    assign poll_busy    = host_rd_data[BUSY_BIT];
    assign poll_expired = (poll_cnt == POLL_W'(TIMEOUT_CYCLES - 1));

    mmio_write_sequencer u_seq (
        .clk         (clk),
        .rst         (rst),
        .issue_first (issue_first),
        .issue_next  (issue_next),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_arg     (req_arg),
        .req_mmvr    (req_mmvr),
        .wr_addr     (seq_addr),
        .wr_data     (seq_data),
        .wr_last     (seq_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a not-busy sample beats an expiring timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = WRITE;
            WRITE:   if (cur_last) next_state = HOLDOFF;
            HOLDOFF: if (hold_cnt == HOLD_W'(POLL_HOLDOFF - 1)) next_state = POLL;
            POLL:    if (!poll_busy || poll_expired) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: handshakes plus the next values of the registered MMIO port.
    always_comb begin
        req_ready      = (state == IDLE);
        rsp_valid      = (state == RESP);
        issue_first    = (state == IDLE) && req_valid;
        issue_next     = (state == WRITE) && !cur_last;
        host_addr_d    = '0;
        host_wr_data_d = '0;
        host_wr_en_d   = 1'b0;
        last_d         = 1'b0;
        if (issue_first || issue_next) begin
            host_addr_d    = seq_addr;
            host_wr_data_d = seq_data;
            host_wr_en_d   = 1'b1;
            last_d         = seq_last;
        end else if (next_state == HOLDOFF || next_state == POLL) begin
            host_addr_d    = `REG_STATUS;
        end
    end

    // MMIO port registers, holdoff/poll counters and the response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            host_addr    <= '0;
            host_wr_data <= '0;
            host_wr_en   <= 1'b0;
            cur_last     <= 1'b0;
            hold_cnt     <= '0;
            poll_cnt     <= '0;
            rsp_status   <= '0;
            rsp_timeout  <= 1'b0;
        end else begin
            host_addr    <= host_addr_d;
            host_wr_data <= host_wr_data_d;
            host_wr_en   <= host_wr_en_d;
            cur_last     <= last_d;
            hold_cnt     <= (state == HOLDOFF) ? hold_cnt + 1'b1 : '0;
            poll_cnt     <= (state == POLL) ? poll_cnt + 1'b1 : '0;
            if (state == POLL) begin
                rsp_status  <= host_rd_data;
                rsp_timeout <= poll_busy && poll_expired;
            end else if (state == RESP && rsp_ready) begin
                rsp_status  <= '0;
                rsp_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmio_cmd_issuer.sv
// Testbench for mmio_cmd_issuer: directed and randomized commands checked
// against a byte-list model of the write phase and a status-poll model.
// Honours MMIO_ISSUER_SKIP_UNCHANGED_EN when the design is built with it.
module tb_mmio_cmd_issuer;

    localparam int HOLDOFF     = 2;
    localparam int TIMEOUT     = 12;
    localparam int BUSY_BIT    = 0;
    localparam logic [7:0] STATUS_ADDR = 8'h0F;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [15:0] req_addr;
    logic [31:0] req_arg;
    logic [63:0] req_mmvr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_status;
    logic        rsp_timeout;
    logic [7:0]  host_addr;
    logic [7:0]  host_wr_data;
    logic        host_wr_en;
    logic [7:0]  host_rd_data;

    int errors = 0;
    int checks = 0;

    logic [15:0] wr_q[$];
    logic [15:0] exp_q[$];
    int          status_reads = 0;
    int          idle_data_viol = 0;
    int          busy_n = 0;
    logic [7:0]  busy_val = 8'h01;
    logic [7:0]  done_val = 8'h00;
    logic [7:0]  shadow_m [15];
    logic [7:0]  last_cmd;
    logic [15:0] last_addr;
    logic [31:0] last_arg;
    logic [63:0] last_mmvr;

    mmio_cmd_issuer #(
        .BUSY_BIT       (BUSY_BIT),
        .POLL_HOLDOFF   (HOLDOFF),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_addr     (req_addr),
        .req_arg      (req_arg),
        .req_mmvr     (req_mmvr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_status   (rsp_status),
        .rsp_timeout  (rsp_timeout),
        .host_addr    (host_addr),
        .host_wr_data (host_wr_data),
        .host_wr_en   (host_wr_en),
        .host_rd_data (host_rd_data)
    );

    always #5 clk = ~clk;

    // Status register of the NPU: busy for the holdoff reads plus busy_n
    // poll reads after the last write, then done.
    assign host_rd_data = (host_addr == STATUS_ADDR) ?
                          ((status_reads <= HOLDOFF + busy_n) ? busy_val : done_val) : 8'h00;

    // Bus monitor: records writes and counts status-read cycles mid-cycle.
    always @(negedge clk) begin
        if (host_wr_en === 1'b1) begin
            wr_q.push_back({host_addr, host_wr_data});
            status_reads = 0;
        end else begin
            if (host_wr_data !== 8'h00) idle_data_viol++;
            if (host_addr == STATUS_ADDR) status_reads++;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected write list: cmd, addr, arg, mmvr bytes little-endian at
    // consecutive addresses 0x00..0x0E; unchanged bytes dropped when skipping,
    // except the doorbell at 0x0E.
    task automatic build_expected(input logic [7:0] cmd, input logic [15:0] addr,
                                  input logic [31:0] arg, input logic [63:0] mmvr);
        logic [119:0] flat;
        logic [7:0]   b;
        flat = {mmvr, arg, addr, cmd};
        exp_q.delete();
        for (int i = 0; i < 15; i++) begin
            b = flat[8*i +: 8];
`ifdef MMIO_ISSUER_SKIP_UNCHANGED_EN
            if (i != 14 && b == shadow_m[i]) continue;
            shadow_m[i] = b;
`endif
            exp_q.push_back({8'(i), b});
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic [7:0] cmd, input logic [15:0] addr,
                                  input logic [31:0] arg, input logic [63:0] mmvr,
                                  input int busy, input int hold_rsp);
        int base;
        int cyc;
        int polls;
        logic [7:0] exp_status;
        logic       exp_to;
        build_expected(cmd, addr, arg, mmvr);
        last_cmd = cmd; last_addr = addr; last_arg = arg; last_mmvr = mmvr;
        busy_n     = busy;
        exp_to     = (busy >= TIMEOUT);
        polls      = exp_to ? TIMEOUT : busy + 1;
        exp_status = exp_to ? busy_val : done_val;
        @(negedge clk);
        check_output({tag, ".req_ready_idle"}, req_ready, 1'b1);
        req_cmd = cmd; req_addr = addr; req_arg = arg; req_mmvr = mmvr;
        req_valid = 1'b1;
        base = wr_q.size();
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (rsp_valid !== 1'b1 && cyc < 400);
        check_output({tag, ".rsp_valid"}, rsp_valid, 1'b1);
        check_output({tag, ".latency"}, cyc, exp_q.size() + HOLDOFF + polls + 1);
        check_output({tag, ".write_count"}, wr_q.size() - base, exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) begin
            check_output($sformatf("%s.write%0d", tag, j),
                         (base + j < wr_q.size()) ? wr_q[base + j] : 16'hxxxx, exp_q[j]);
        end
        check_output({tag, ".rsp_status"}, rsp_status, exp_status);
        check_output({tag, ".rsp_timeout"}, rsp_timeout, exp_to);
        for (int k = 0; k < hold_rsp; k++) begin
            @(negedge clk);
            check_output($sformatf("%s.hold%0d_valid", tag, k), rsp_valid, 1'b1);
            check_output($sformatf("%s.hold%0d_status", tag, k), rsp_status, exp_status);
            check_output($sformatf("%s.hold%0d_timeout", tag, k), rsp_timeout, exp_to);
            check_output($sformatf("%s.hold%0d_req_ready", tag, k), req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        #1 check_output({tag, ".req_ready_in_resp"}, req_ready, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_output({tag, ".rsp_valid_after"}, rsp_valid, 1'b0);
        check_output({tag, ".req_ready_after"}, req_ready, 1'b1);
    endtask

    task automatic apply_reset_mid(input logic [7:0] cmd, input logic [15:0] addr,
                                   input logic [31:0] arg, input logic [63:0] mmvr);
        @(negedge clk);
        req_cmd = cmd; req_addr = addr; req_arg = arg; req_mmvr = mmvr;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (7) @(negedge clk);
        check_output("rstmid.wr_en_7th", host_wr_en, 1'b1);
        check_output("rstmid.addr_7th", host_addr, 8'h06);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rstmid.wr_en", host_wr_en, 1'b0);
        check_output("rstmid.req_ready", req_ready, 1'b1);
        check_output("rstmid.rsp_valid", rsp_valid, 1'b0);
        check_output("rstmid.addr", host_addr, 8'h00);
        for (int i = 0; i < 15; i++) shadow_m[i] = 8'h00;
    endtask

    initial begin
        logic [119:0] flat;
        int           k;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_cmd = '0; req_addr = '0; req_arg = '0; req_mmvr = '0;
        for (int i = 0; i < 15; i++) shadow_m[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset.req_ready", req_ready, 1'b1);
        check_output("reset.rsp_valid", rsp_valid, 1'b0);
        check_output("reset.wr_en", host_wr_en, 1'b0);
        check_output("reset.addr", host_addr, 8'h00);
        check_output("reset.wr_data", host_wr_data, 8'h00);
        check_output("reset.status", rsp_status, 8'h00);
        check_output("reset.timeout", rsp_timeout, 1'b0);
        rst = 1'b0;

        $display("[TB] directed commands");
        apply_stimulus("basic", 8'h01, 16'hBEEF, 32'h11223344, 64'h8877665544332211, 0, 0);
        apply_stimulus("busy10", 8'h01, 16'hBEEF, 32'h11223344, 64'h8877665544332211, 10, 0);
        apply_stimulus("arg_byte1", 8'h01, 16'hBEEF, 32'h11225544, 64'h8877665544332211, TIMEOUT - 1, 0);
        apply_stimulus("timeout", 8'h02, 16'h1234, 32'hCAFEF00D, 64'h0123456789ABCDEF, TIMEOUT, 5);
        busy_val = 8'h81; done_val = 8'h40;
        apply_stimulus("stuck", 8'h03, 16'h1234, 32'hCAFEF00D, 64'h0123456789ABCDEF, 40, 2);

        $display("[TB] reset in the middle of the write phase");
        apply_reset_mid(~last_cmd, ~last_addr, ~last_arg, ~last_mmvr);
        apply_stimulus("after_reset", 8'h05, 16'h0A0B, 32'h0C0D0E0F, 64'h1020304050607080, 3, 1);

        $display("[TB] randomized commands");
        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                flat = {last_mmvr, last_arg, last_addr, last_cmd};
                k = $urandom_range(0, 14);
                flat[8*k +: 8] = flat[8*k +: 8] ^ 8'h5A;
            end else begin
                flat = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            busy_val = 8'($urandom()) | 8'h01;
            done_val = 8'($urandom()) & 8'hFE;
            apply_stimulus($sformatf("rand%0d", n), flat[7:0], flat[23:8], flat[55:24], flat[119:56],
                           $urandom_range(0, 14), $urandom_range(0, 3));
        end

        check_output("wr_data_zero_when_idle", idle_data_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
